// File: rtl/joypad_pkg.sv
// joypad_pkg
// Shared types and constants for the joypad poll scheduler.
//   pollState_e      : poll sequencer states
//   BTN_A..BTN_RIGHT : bit positions of each button in the button bytes
//   NUM_BUTTONS      : number of serial bits read from each pad
package joypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        PULSE_HI,
        PULSE_LO,
        DONE
    } pollState_e;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NUM_BUTTONS = 8;

endpackage

// File: rtl/pad_sync.sv
// pad_sync
// Two-flop synchronizer for one serial pad data line. Both flops reset to 1,
// which is the released (not pressed) level of the active-low pad data.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous pad data
//   q_o    : synchronized pad data
module pad_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; the first stage may go metastable, the second resolves it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/joypad_poll_scheduler.sv
// joypad_poll_scheduler
// Reads two serial joypads (4021-style shift registers) through a shared latch
// and shift clock, on software request or periodically.
//   clk            : system clock
//   Reset          : asynchronous active-low reset
//   poll_req       : one-cycle software poll request
//   auto_en        : enables periodic polling every POLL_TICKS cycles
//   pad0_data      : serial data from connector 0, active-low
//   pad1_data      : serial data from connector 1, active-low
//   pad_latch      : shared latch to both pads
//   pad_clk        : shared shift clock, idle low
//   pad0_buttons   : connector 0 buttons, active-high, bit order A,B,Sel,Start,Up,Down,Left,Right
//   pad1_buttons   : connector 1 buttons (8'h00 when the second port is disabled)
//   busy           : high while a poll is in progress
//   valid          : one-cycle strobe when new button values are presented
// Configuration macro:
//   JOYPAD_PORT2_EN : when defined, connector 1 is synchronized and sampled;
//                     otherwise pad1_data is ignored and pad1_buttons is 8'h00.
module joypad_poll_scheduler
    import joypad_pkg::*;
#(
    parameter int LATCH_TICKS = 600,
    parameter int HALF_TICKS  = 300,
    parameter int POLL_TICKS  = 833333
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       poll_req,
    input  logic       auto_en,
    input  logic       pad0_data,
    input  logic       pad1_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] pad0_buttons,
    output logic [7:0] pad1_buttons,
    output logic       busy,
    output logic       valid
);

    localparam int TICK_MAX = (LATCH_TICKS > HALF_TICKS) ? LATCH_TICKS : HALF_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX);
    localparam int PER_W    = $clog2(POLL_TICKS);

    localparam logic [TICK_W-1:0] LATCH_LAST    = TICK_W'(LATCH_TICKS - 1);
    localparam logic [TICK_W-1:0] HALF_LAST     = TICK_W'(HALF_TICKS - 1);
    localparam logic [PER_W-1:0]  PERIOD_RELOAD = PER_W'(POLL_TICKS - 1);

    pollState_e        state_q;
    logic [TICK_W-1:0] tickCnt_q;
    logic [2:0]        bitIdx_q;
    logic              latch_q;
    logic              padClk_q;
    logic              busy_q;
    logic              valid_q;
    logic              pending_q;
    logic              pending_d;
    logic [PER_W-1:0]  periodCnt_q;
    logic [PER_W-1:0]  periodCnt_d;

    logic periodExpired;
    logic startPoll;
    logic latchDone;
    logic halfDone;
    logic sampleNow;
    logic sampleLast;

    logic       pad0Sync;
    logic [6:0] pad0Shift_q;
    logic [7:0] pad0Btn_q;

    pad_sync u_pad0Sync (
        .clk_i  (clk),
        .rst_ni (Reset),
        .d_i    (pad0_data),
        .q_o    (pad0Sync)
    );

    // Start sources are merged so that any combination in one cycle starts a
    // single poll; sources seen while busy collapse into one pending flag.
    always_comb begin
        periodExpired = auto_en && (periodCnt_q == '0);
        startPoll     = (state_q == IDLE) && (poll_req || pending_q || periodExpired);
        pending_d     = pending_q;
        if (startPoll) begin
            pending_d = 1'b0;
        end else if ((state_q != IDLE) && (poll_req || periodExpired)) begin
            pending_d = 1'b1;
        end
    end

    // Period counter is held at zero while disabled, so enabling auto mode
    // fires a poll right away and then every POLL_TICKS cycles.
    always_comb begin
        periodCnt_d = periodCnt_q;
        if (!auto_en) begin
            periodCnt_d = '0;
        end else if (periodExpired) begin
            periodCnt_d = PERIOD_RELOAD;
        end else begin
            periodCnt_d = periodCnt_q - PER_W'(1);
        end
    end

    // Bit 0 is taken at the end of the latch pulse, bits 1..7 at the end of the
    // low phase of each shift pulse, when the synchronized data has settled.
    assign latchDone  = (state_q == LATCH) && (tickCnt_q == LATCH_LAST);
    assign halfDone   = (tickCnt_q == HALF_LAST);
    assign sampleNow  = latchDone || ((state_q == PULSE_LO) && halfDone);
    assign sampleLast = (state_q == PULSE_LO) && halfDone && (bitIdx_q == 3'd7);

    // Poll sequencer with registered pad and status outputs
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            tickCnt_q   <= '0;
            bitIdx_q    <= '0;
            latch_q     <= 1'b0;
            padClk_q    <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            pending_q   <= 1'b0;
            periodCnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            periodCnt_q <= periodCnt_d;
            valid_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (startPoll) begin
                        state_q   <= LATCH;
                        latch_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        tickCnt_q <= '0;
                        bitIdx_q  <= '0;
                    end
                end
                LATCH: begin
                    if (latchDone) begin
                        state_q   <= PULSE_HI;
                        latch_q   <= 1'b0;
                        padClk_q  <= 1'b1;
                        tickCnt_q <= '0;
                        bitIdx_q  <= 3'd1;
                    end else begin
                        tickCnt_q <= tickCnt_q + TICK_W'(1);
                    end
                end
                PULSE_HI: begin
                    if (halfDone) begin
                        state_q   <= PULSE_LO;
                        padClk_q  <= 1'b0;
                        tickCnt_q <= '0;
                    end else begin
                        tickCnt_q <= tickCnt_q + TICK_W'(1);
                    end
                end
                PULSE_LO: begin
                    if (halfDone) begin
                        tickCnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state_q  <= PULSE_HI;
                            padClk_q <= 1'b1;
                            bitIdx_q <= bitIdx_q + 3'd1;
                        end
                    end else begin
                        tickCnt_q <= tickCnt_q + TICK_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    latch_q  <= 1'b0;
                    padClk_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Bits enter at the top and move down, so after seven samples bit 0 sits in
    // position 0; the eighth sample goes straight into the output byte so both
    // pads' outputs change together with the valid strobe.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pad0Shift_q <= '0;
            pad0Btn_q   <= '0;
        end else if (sampleNow) begin
            if (sampleLast) begin
                pad0Btn_q <= {~pad0Sync, pad0Shift_q};
            end else begin
                pad0Shift_q <= {~pad0Sync, pad0Shift_q[6:1]};
            end
        end
    end

`ifdef JOYPAD_PORT2_EN
    logic       pad1Sync;
    logic [6:0] pad1Shift_q;
    logic [7:0] pad1Btn_q;

    pad_sync u_pad1Sync (
        .clk_i  (clk),
        .rst_ni (Reset),
        .d_i    (pad1_data),
        .q_o    (pad1Sync)
    );

    // Second connector shifts in lockstep with the first
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pad1Shift_q <= '0;
            pad1Btn_q   <= '0;
        end else if (sampleNow) begin
            if (sampleLast) begin
                pad1Btn_q <= {~pad1Sync, pad1Shift_q};
            end else begin
                pad1Shift_q <= {~pad1Sync, pad1Shift_q[6:1]};
            end
        end
    end

    assign pad1_buttons = pad1Btn_q;
`else
    logic unusedPad1;

    assign unusedPad1   = pad1_data;
    assign pad1_buttons = 8'h00;
`endif

    assign pad_latch    = latch_q;
    assign pad_clk      = padClk_q;
    assign busy         = busy_q;
    assign valid        = valid_q;
    assign pad0_buttons = pad0Btn_q;

endmodule

// File: tb/tb_joypad_poll_scheduler.sv
// tb_joypad_poll_scheduler
// Scoreboard bench for joypad_poll_scheduler with short timing parameters.
// A behavioural pad model snapshots the pressed buttons on each latch pulse and
// queues the expected button bytes; a monitor pops them on every valid strobe.
module tb_joypad_poll_scheduler;

    localparam int L = 4;
    localparam int H = 2;
    localparam int P = 100;
    // Cycles from the start cycle of a poll to its valid strobe
    localparam int POLL_LEN = L + 14 * H + 1;

    typedef struct {
        logic [7:0] p0;
        logic [7:0] p1;
    } expect_t;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       poll_req = 1'b0;
    logic       auto_en = 1'b0;
    logic       pad0_data;
    logic       pad1_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] pad0_buttons;
    logic [7:0] pad1_buttons;
    logic       busy;
    logic       valid;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int validCount = 0;
    int padClkRises = 0;
    int bitPtr = 8;
    int validCycles[$];
    expect_t expQ[$];

    logic [7:0] pads0 = 8'h00;
    logic [7:0] latched0 = 8'h00;
    logic [7:0] heldExp0 = 8'h00;
    logic [7:0] heldExp1 = 8'h00;
`ifdef JOYPAD_PORT2_EN
    logic [7:0] pads1 = 8'h00;
    logic [7:0] latched1 = 8'h00;
`endif

    joypad_poll_scheduler #(
        .LATCH_TICKS (L),
        .HALF_TICKS  (H),
        .POLL_TICKS  (P)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .poll_req     (poll_req),
        .auto_en      (auto_en),
        .pad0_data    (pad0_data),
        .pad1_data    (pad1_data),
        .pad_latch    (pad_latch),
        .pad_clk      (pad_clk),
        .pad0_buttons (pad0_buttons),
        .pad1_buttons (pad1_buttons),
        .busy         (busy),
        .valid        (valid)
    );

    always #5 clk = ~clk;

    // Cycle number since the last reset release
    always @(posedge clk or negedge Reset) begin
        if (!Reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Pad model: latch loads the pressed buttons, each shift clock rise advances
    // one bit; serial line is low for a pressed button, high once exhausted.
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) begin
            latched0 = pads0;
`ifdef JOYPAD_PORT2_EN
            latched1 = pads1;
            expQ.push_back('{p0: pads0, p1: pads1});
`else
            expQ.push_back('{p0: pads0, p1: 8'h00});
`endif
            bitPtr = 0;
        end else begin
            padClkRises++;
            if (bitPtr < 8) bitPtr = bitPtr + 1;
        end
    end

    assign pad0_data = (bitPtr < 8) ? ~latched0[bitPtr[2:0]] : 1'b1;
`ifdef JOYPAD_PORT2_EN
    assign pad1_data = (bitPtr < 8) ? ~latched1[bitPtr[2:0]] : 1'b1;
`else
    assign pad1_data = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, actual, required);
        end
    endtask

    // Monitor: every valid pops one expectation; between strobes the outputs
    // must hold the last expected bytes (zero after reset).
    always @(negedge clk) begin
        expect_t e;
        if (!Reset) begin
            heldExp0 = 8'h00;
            heldExp1 = 8'h00;
        end else if (valid) begin
            validCount++;
            validCycles.push_back(cyc);
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpectedValid at cycle %0d: got valid=1 with no poll outstanding, required none", cyc);
            end else begin
                e = expQ.pop_front();
                checkOutput("pad0_buttons", {24'd0, pad0_buttons}, {24'd0, e.p0});
                checkOutput("pad1_buttons", {24'd0, pad1_buttons}, {24'd0, e.p1});
                heldExp0 = e.p0;
                heldExp1 = e.p1;
            end
        end else begin
            checkOutput("pad0Held", {24'd0, pad0_buttons}, {24'd0, heldExp0});
            checkOutput("pad1Held", {24'd0, pad1_buttons}, {24'd0, heldExp1});
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitForCycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus();
        poll_req = 1'b1;
        @(posedge clk);
        #1;
        poll_req = 1'b0;
    endtask

    task automatic waitValids(input int target, input int budget);
        int spent = 0;
        while (validCount < target && spent < budget) begin
            @(posedge clk);
            #1;
            spent++;
        end
        checkOutput("validArrival", (validCount >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic waitQuiet(input int budget);
        int quiet = 0;
        int spent = 0;
        while (quiet < 3 && spent < budget) begin
            @(posedge clk);
            #1;
            spent++;
            if (!busy && expQ.size() == 0) quiet++;
            else quiet = 0;
        end
        checkOutput("settleWithinBudget", (quiet >= 3) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Expected {latch, pad_clk, busy, valid} in cycle c of a poll started in cycle n
    function automatic logic [3:0] expWave(input int n, input int c);
        int off;
        logic lat, pc, bs, vl;
        off = c - n;
        lat = (off >= 1) && (off <= L);
        pc  = (off >= L + 1) && (off <= L + 14 * H) && ((((off - L - 1) / H) % 2) == 0);
        bs  = (off >= 1) && (off <= POLL_LEN);
        vl  = (off == POLL_LEN);
        return {lat, pc, bs, vl};
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int startCyc;
        int v3;
        int rises;
        logic [3:0] w;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetLatch", {31'd0, pad_latch}, 32'd0);
        checkOutput("resetPadClk", {31'd0, pad_clk}, 32'd0);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetValid", {31'd0, valid}, 32'd0);
        checkOutput("resetPad0", {24'd0, pad0_buttons}, 32'd0);
        checkOutput("resetPad1", {24'd0, pad1_buttons}, 32'd0);
        Reset = 1'b1;

        // Directed timing: request in cycle 10, strobe in cycle 43, pattern 8'h89
        $display("[TB] directed poll timing");
        pads0 = 8'h89;
        rises = padClkRises;
        base = validCount;
        waitForCycle(10);
        poll_req = 1'b1;
        for (int k = 0; k < POLL_LEN + 4; k++) begin
            @(negedge clk);
            w = expWave(10, cyc);
            checkOutput("latchWave", {31'd0, pad_latch}, {31'd0, w[3]});
            checkOutput("padClkWave", {31'd0, pad_clk}, {31'd0, w[2]});
            checkOutput("busyWave", {31'd0, busy}, {31'd0, w[1]});
            checkOutput("validWave", {31'd0, valid}, {31'd0, w[0]});
            if (cyc == 11) poll_req = 1'b0;
        end
        checkOutput("directedValidCount", validCount - base, 32'd1);
        checkOutput("padClkPulses", padClkRises - rises, 32'd7);
        checkOutput("pad0Pattern", {24'd0, pad0_buttons}, 32'h89);
        if (validCycles.size() > base) checkOutput("validCycle43", validCycles[base], 32'd43);
        waitQuiet(100);

        // Two requests while busy collapse into one back-to-back poll
        $display("[TB] double request during busy poll");
        pads0 = 8'($urandom);
        base = validCount;
        startCyc = cyc;
        applyStimulus();
        waitCycles(5);
        applyStimulus();
        waitCycles(4);
        applyStimulus();
        waitValids(base + 2, 150);
        waitCycles(60);
        checkOutput("doubleReqValids", validCount - base, 32'd2);
        if (validCycles.size() >= base + 2) begin
            checkOutput("firstValidCycle", validCycles[base], startCyc + POLL_LEN);
            checkOutput("backToBackValid", validCycles[base + 1], startCyc + 2 * POLL_LEN + 1);
        end
        waitQuiet(100);

        // Randomized polls with random extra requests
        $display("[TB] random polls");
        for (int i = 0; i < 10; i++) begin
            pads0 = 8'($urandom);
`ifdef JOYPAD_PORT2_EN
            pads1 = 8'($urandom);
`endif
            waitCycles($urandom_range(0, 15));
            applyStimulus();
            if ($urandom_range(0, 1) == 1) begin
                waitCycles($urandom_range(1, 25));
                applyStimulus();
            end
            waitQuiet(300);
        end

        // Periodic polling, then a poll_req coinciding with an expiry
        $display("[TB] auto polling");
        pads0 = 8'($urandom);
        base = validCount;
        auto_en = 1'b1;
        waitValids(base + 3, 400);
        if (validCycles.size() >= base + 3) begin
            checkOutput("autoSpacing1", validCycles[base + 1] - validCycles[base], P);
            checkOutput("autoSpacing2", validCycles[base + 2] - validCycles[base + 1], P);
            v3 = validCycles[base + 2];
            waitForCycle(v3 + P - POLL_LEN);
            applyStimulus();
            waitForCycle(v3 + 2 * P + 5);
            checkOutput("coincidentReqValids", validCount - (base + 3), 32'd2);
            if (validCycles.size() >= base + 5) begin
                checkOutput("autoSpacing3", validCycles[base + 3] - v3, P);
                checkOutput("autoSpacing4", validCycles[base + 4] - validCycles[base + 3], P);
            end
        end
        auto_en = 1'b0;
        waitQuiet(200);

        // Reset in the middle of a poll
        $display("[TB] reset during poll");
        pads0 = 8'h5A;
        applyStimulus();
        waitQuiet(100);
        pads0 = 8'h3C;
        startCyc = cyc;
        applyStimulus();
        waitForCycle(startCyc + 20);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("midResetLatch", {31'd0, pad_latch}, 32'd0);
        checkOutput("midResetPadClk", {31'd0, pad_clk}, 32'd0);
        checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
        checkOutput("midResetValid", {31'd0, valid}, 32'd0);
        checkOutput("midResetPad0", {24'd0, pad0_buttons}, 32'd0);
        checkOutput("midResetPad1", {24'd0, pad1_buttons}, 32'd0);
        expQ.delete();
        base = validCount;
        repeat (4) @(posedge clk);
        #1;
        Reset = 1'b1;
        waitCycles(10);
        checkOutput("noValidAcrossReset", validCount - base, 32'd0);
        checkOutput("pad0AfterReset", {24'd0, pad0_buttons}, 32'd0);
        applyStimulus();
        waitValids(base + 1, 100);
        waitQuiet(100);
        checkOutput("pollAfterReset", {24'd0, pad0_buttons}, 32'h3C);
        checkOutput("pollAfterResetCount", validCount - base, 32'd1);

`ifndef JOYPAD_PORT2_EN
        checkOutput("pad1StaysZero", {24'd0, pad1_buttons}, 32'd0);
`endif
        checkOutput("scoreboardDrained", expQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/joypad_poll_scheduler.md
JOYPAD_POLL_SCHEDULER -- requirements
Module: joypad_poll_scheduler

Interface
REQ-001 SHALL have parameter LATCH_TICKS, default 600, meaning latch-high duration in clk cycles (>=2).
REQ-002 SHALL have parameter HALF_TICKS, default 300, meaning pad_clk high and low phase duration in clk cycles (>=1).
REQ-003 SHALL have parameter POLL_TICKS, default 833333, meaning auto-poll period in clk cycles (> one poll duration).
REQ-004 SHALL have ports: clk  input  1  system clock; Reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports: poll_req  input  1  one-cycle software poll request; auto_en  input  1  enables periodic polling.
REQ-006 SHALL have ports: pad0_data, pad1_data  input  1 each  serial data from connectors, active-low (low = pressed).
REQ-007 SHALL have ports: pad_latch  output  1  shared latch; pad_clk  output  1  shared shift clock, idle low.
REQ-008 SHALL have ports: pad0_buttons, pad1_buttons  output  8 each  button states, active-high; busy  output  1; valid  output  1  one-cycle completion strobe.

Function
REQ-009 SHALL order bits as bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
REQ-010 SHALL implement states IDLE, LATCH, PULSE_HI, PULSE_LO, DONE with a single tick counter and a 3-bit bit index.
REQ-011 SHALL, in IDLE with a start condition in cycle N, assert pad_latch in cycles N+1..N+LATCH_TICKS.
REQ-012 SHALL sample synchronized, inverted data for bit0 on the last LATCH cycle.
REQ-013 SHALL then run 7 pulses: pad_clk high for HALF_TICKS (PULSE_HI), low for HALF_TICKS (PULSE_LO), sampling bit k on the last PULSE_LO cycle of pulse k.
REQ-014 SHALL shift both ports in parallel into internal registers and update pad0_buttons and pad1_buttons only in DONE, atomically.
REQ-015 SHALL assert valid for exactly one cycle in DONE at cycle N+LATCH_TICKS+14*HALF_TICKS+1, then return to IDLE.
REQ-016 SHALL assert busy in every non-IDLE state.
REQ-017 SHALL form start condition = poll_req OR pending OR (auto_en AND period counter expired); simultaneous sources start exactly one poll.
REQ-018 SHALL set a single pending flag on poll_req while busy; further requests while pending is set SHALL be dropped; pending clears when its poll starts.
REQ-019 SHALL run the period counter only while auto_en=1, reload it to POLL_TICKS-1 on expiry, and clear it when auto_en=0; expiry while busy sets pending.
REQ-020 SHALL pass pad0_data and pad1_data through 2-flop synchronizers before sampling.

Reset
REQ-021 SHALL, on Reset low, asynchronously force IDLE, pad_latch=0, pad_clk=0, busy=0, valid=0, pending=0, counters=0, pad0_buttons=8'h00, pad1_buttons=8'h00, and synchronizer flops to 1 (released).
REQ-022 SHALL, on reset asserted mid-poll, abandon the poll without a valid strobe and without updating button outputs.

Configuration
REQ-023 SHALL, with JOYPAD_PORT2_EN defined, sample pad1_data as specified above.
REQ-024 SHALL, without JOYPAD_PORT2_EN, omit the pad1 synchronizer and shift register, tie pad1_buttons to 8'h00, and ignore pad1_data.

Structure
REQ-025 SHALL place the state enum typedef and the button bit-index constants (BTN_A..BTN_RIGHT) in shared package joypad_pkg.
REQ-026 SHALL instantiate sub-module pad_sync (2-flop synchronizer, reset value 1) once per enabled data input.

Verification
REQ-027 SHALL be tested with LATCH_TICKS=4, HALF_TICKS=2, POLL_TICKS=100: poll_req at cycle 10 -> latch high cycles 11-14, 7 pad_clk pulses, valid at cycle 43, busy high for cycles 11-43.
REQ-028 SHALL be tested with a pad0 model returning serial 0,1,1,0,1,1,1,0 (A..Right) -> pad0_buttons=8'h89.
REQ-029 SHALL be tested with poll_req pulsed twice during a busy poll -> exactly one additional poll immediately after DONE, two valid strobes in total.
REQ-030 SHALL be tested with auto_en=1 and no poll_req -> valid strobes spaced exactly 100 cycles apart; a coincident poll_req adds no extra poll.
REQ-031 SHALL be tested with Reset low at cycle 20 of a poll -> all outputs at reset values, no valid, and a normal poll after release.
REQ-032 SHALL be tested with JOYPAD_PORT2_EN undefined and pad1_data driven low -> pad1_buttons stays 8'h00.
